// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read bus between the fetch stage and the L1 I-side.
// One request outstanding; imem_ready marks the response cycle.
interface instr_fetch_unit_if #(
  parameter int pc_size    = 32,
  parameter int instr_size = 32
) ();
  logic                  imem_req;
  logic [pc_size-1:0]    imem_addr;
  logic                  imem_ready;
  logic [instr_size-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding L1 read, small FIFO of {instr, pc} to decode.
// fetch_busy holds program_counter until a new fetch can be launched.
module instr_fetch_unit #(
  parameter int pc_size    = 32,
  parameter int instr_size = 32,
  parameter int fb_depth   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [pc_size-1:0]    pc_next,
  input  logic                  branch_instruction,
  input  logic                  decode_stall,
  instr_fetch_unit_if.master    imem,
  output logic                  instr_valid,
  output logic [instr_size-1:0] instr_out,
  output logic [pc_size-1:0]    instr_pc,
  output logic                  fetch_busy
);

  localparam int pw = $clog2(fb_depth);
  localparam int cw = pw + 1;
  localparam logic [cw-1:0] full_cnt = cw'(fb_depth);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t state, state_nx;

  logic [cw-1:0]         count;
  logic [pw-1:0]         rd_ptr, wr_ptr;
  logic [instr_size-1:0] fb_instr [fb_depth];
  logic [pc_size-1:0]    fb_pc    [fb_depth];
  logic [pc_size-1:0]    addr_q, tag_pc;

  logic full, launch, push, pop, req;

  assign full = (count == full_cnt);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (!full && !branch_instruction) state_nx = REQ;
      REQ: begin
        if (imem.imem_ready)         state_nx = IDLE;
        else if (branch_instruction) state_nx = DROP;
      end
      DROP: if (imem.imem_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req    = (state != IDLE);
    launch = (state == IDLE) && !full && !branch_instruction;
    push   = (state == REQ) && imem.imem_ready && !branch_instruction;
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = addr_q;
  assign fetch_busy     = (state != IDLE) || full;

  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q <= '0;
      tag_pc <= '0;
    end else if (launch) begin
      addr_q <= {pc_next[pc_size-1:2], 2'b00};
      tag_pc <= pc_next;
    end
  end

  assign instr_valid = (count != '0);
  assign pop         = instr_valid && !decode_stall;
  assign instr_out   = instr_valid ? fb_instr[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? fb_pc[rd_ptr]    : '0;

  // flush wins over any same-cycle push or pop
  always_ff @(posedge clk) begin
    if (!reset) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (branch_instruction) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + cw'(push) - cw'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fb_instr[wr_ptr] <= imem.imem_rdata;
      fb_pc[wr_ptr]    <= tag_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed cycle vectors for instr_fetch_unit: stream, stall/full,
// dual push-pop, branch drop, branch+ready, reset mid-request.
module tb_instr_fetch_unit;

  typedef struct {
    logic        rst_n;
    logic [31:0] pc;
    logic        br;
    logic        stall;
    logic        rdy;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_out;
    logic [31:0] e_ipc;
    logic        e_busy;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_next;
  logic        branch_instruction;
  logic        decode_stall;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        fetch_busy;

  int total = 0;
  int bad   = 0;
  bit seen_dead = 1'b0;

  instr_fetch_unit_if #(.pc_size(32), .instr_size(32)) imem ();

  instr_fetch_unit #(
    .pc_size(32),
    .instr_size(32),
    .fb_depth(2)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .pc_next            (pc_next),
    .branch_instruction (branch_instruction),
    .decode_stall       (decode_stall),
    .imem               (imem.master),
    .instr_valid        (instr_valid),
    .instr_out          (instr_out),
    .instr_pc           (instr_pc),
    .fetch_busy         (fetch_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (instr_out == 32'hDEAD_BEEF) seen_dead = 1'b1;

  function automatic vec_t mk(
    input logic rst_n, input logic [31:0] pc, input logic br,
    input logic stall, input logic rdy, input logic [31:0] rdata,
    input logic e_req, input logic [31:0] e_addr, input logic e_vld,
    input logic [31:0] e_out, input logic [31:0] e_ipc,
    input logic e_busy);
    vec_t v;
    v.rst_n = rst_n; v.pc = pc; v.br = br; v.stall = stall;
    v.rdy = rdy; v.rdata = rdata;
    v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld;
    v.e_out = e_out; v.e_ipc = e_ipc; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string tag, input string f,
                     input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s.%s got=%h want=%h", tag, f, got, exp);
    end
  endtask

  // drive away from the edge, then check state entering this cycle
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    reset              = v.rst_n;
    pc_next            = v.pc;
    branch_instruction = v.br;
    decode_stall       = v.stall;
    imem.imem_ready    = v.rdy;
    imem.imem_rdata    = v.rdata;
    #1;
    chk(tag, "req",  {31'd0, imem.imem_req}, {31'd0, v.e_req});
    chk(tag, "addr", imem.imem_addr, v.e_addr);
    chk(tag, "vld",  {31'd0, instr_valid}, {31'd0, v.e_vld});
    chk(tag, "out",  instr_out, v.e_out);
    chk(tag, "ipc",  instr_pc, v.e_ipc);
    chk(tag, "busy", {31'd0, fetch_busy}, {31'd0, v.e_busy});
  endtask

  localparam logic [31:0] D = 32'hDEAD_BEEF;
  localparam logic [31:0] B = 32'h1000_0000;

  vec_t tbl [20];

  initial begin
    //           rst pc     br st rdy rdata    req addr   vld out      ipc    busy
    tbl[0]  = mk(1, 32'h00, 0, 0, 0, 0,        0, 32'h00, 0, 0,        0,     0);
    tbl[1]  = mk(1, 32'h04, 0, 0, 1, B+32'h00, 1, 32'h00, 0, 0,        0,     1);
    tbl[2]  = mk(1, 32'h04, 0, 0, 0, 0,        0, 32'h00, 1, B+32'h00, 32'h00, 0);
    tbl[3]  = mk(1, 32'h08, 0, 0, 1, B+32'h04, 1, 32'h04, 0, 0,        0,     1);
    tbl[4]  = mk(1, 32'h08, 0, 0, 0, 0,        0, 32'h04, 1, B+32'h04, 32'h04, 0);
    tbl[5]  = mk(1, 32'h0C, 0, 0, 1, B+32'h08, 1, 32'h08, 0, 0,        0,     1);
    tbl[6]  = mk(1, 32'h0C, 0, 1, 0, 0,        0, 32'h08, 1, B+32'h08, 32'h08, 0);
    tbl[7]  = mk(1, 32'h10, 0, 1, 1, B+32'h0C, 1, 32'h0C, 1, B+32'h08, 32'h08, 1);
    tbl[8]  = mk(1, 32'h10, 0, 1, 0, 0,        0, 32'h0C, 1, B+32'h08, 32'h08, 1);
    tbl[9]  = mk(1, 32'h10, 0, 1, 0, 0,        0, 32'h0C, 1, B+32'h08, 32'h08, 1);
    tbl[10] = mk(1, 32'h10, 0, 0, 0, 0,        0, 32'h0C, 1, B+32'h08, 32'h08, 1);
    tbl[11] = mk(1, 32'h10, 0, 0, 0, 0,        0, 32'h0C, 1, B+32'h0C, 32'h0C, 0);
    tbl[12] = mk(1, 32'h14, 0, 0, 0, 0,        1, 32'h10, 0, 0,        0,     1);
    tbl[13] = mk(1, 32'h14, 0, 1, 1, B+32'h10, 1, 32'h10, 0, 0,        0,     1);
    tbl[14] = mk(1, 32'h14, 0, 1, 0, 0,        0, 32'h10, 1, B+32'h10, 32'h10, 0);
    tbl[15] = mk(1, 32'h18, 0, 0, 1, B+32'h14, 1, 32'h14, 1, B+32'h10, 32'h10, 1);
    tbl[16] = mk(1, 32'h18, 0, 1, 0, 0,        0, 32'h14, 1, B+32'h14, 32'h14, 0);
    tbl[17] = mk(1, 32'h18, 0, 0, 0, 0,        1, 32'h18, 1, B+32'h14, 32'h14, 1);
    tbl[18] = mk(1, 32'h18, 0, 0, 1, B+32'h18, 1, 32'h18, 0, 0,        0,     1);
    tbl[19] = mk(1, 32'h1C, 0, 0, 0, 0,        0, 32'h18, 1, B+32'h18, 32'h18, 0);

    reset              = 1'b0;
    pc_next            = '0;
    branch_instruction = 1'b0;
    decode_stall       = 1'b0;
    imem.imem_ready    = 1'b0;
    imem.imem_rdata    = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 20; i++)
      apply(tbl[i], $sformatf("row%0d", i));

    // branch while waiting: response dropped, redirected PC fetched
    apply(mk(1, 32'h100, 1, 0, 0, 0, 1, 32'h1C, 0, 0, 0, 1), "drop_a");
    apply(mk(1, 32'h100, 0, 0, 0, 0, 1, 32'h1C, 0, 0, 0, 1), "drop_b");
    apply(mk(1, 32'h100, 0, 0, 0, 0, 1, 32'h1C, 0, 0, 0, 1), "drop_c");
    apply(mk(1, 32'h100, 0, 0, 1, D, 1, 32'h1C, 0, 0, 0, 1), "drop_d");
    apply(mk(1, 32'h100, 0, 0, 0, 0, 0, 32'h1C, 0, 0, 0, 0), "drop_e");
    apply(mk(1, 32'h104, 0, 0, 1, B+32'h100,
             1, 32'h100, 0, 0, 0, 1), "drop_f");
    apply(mk(1, 32'h104, 0, 0, 0, 0,
             0, 32'h100, 1, B+32'h100, 32'h100, 0), "drop_g");

    // branch and ready in the same REQ cycle
    apply(mk(1, 32'h200, 1, 0, 1, D, 1, 32'h104, 0, 0, 0, 1), "brrdy_a");
    apply(mk(1, 32'h200, 0, 0, 0, 0, 0, 32'h104, 0, 0, 0, 0), "brrdy_b");

    // reset mid-request, late ready ignored
    apply(mk(0, 32'h000, 0, 0, 0, 0, 1, 32'h200, 0, 0, 0, 1), "rst_a");
    apply(mk(0, 32'h000, 0, 0, 0, 0, 0, 32'h000, 0, 0, 0, 0), "rst_b");
    apply(mk(1, 32'h000, 0, 0, 1, D, 0, 32'h000, 0, 0, 0, 0), "rst_c");
    apply(mk(1, 32'h004, 0, 0, 1, B, 1, 32'h000, 0, 0, 0, 1), "rst_d");
    apply(mk(1, 32'h004, 0, 0, 0, 0, 0, 32'h000, 1, B, 0, 0), "rst_e");

    total++;
    if (seen_dead) begin
      bad++;
      $display("FAIL dropped_data got=seen want=never");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
